ena_debounce: RTL

ENA_DEBOUNCE -- requirements
Module: ena_debounce

---
 rtl/ena_debounce.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/ena_debounce.sv
// ena_debounce
// Debounces a raw push-button and derives a count enable for a downstream
// counter. The button is synchronised into clk, then a four-state FSM
// requires DEB_CYCLES consecutive stable samples before it accepts a level
// change. Accepted presses either toggle ena (TOGGLE_MODE=1) or ena simply
// follows the debounced level (TOGGLE_MODE=0).
//
// Ports:
//   clk           system clock
//   rst           asynchronous, active-high reset
//   btn_in        raw, bouncing, asynchronous button pin (active-high)
//   ena           count enable (ENA_RESET during/after reset)
//   btn_level     debounced button level
//   press_pulse   one-cycle strobe on an accepted press
//   release_pulse one-cycle strobe on an accepted release
//   press_count   accepted presses, modulo 256
//
// state        | meaning
// IDLE         | button accepted as released
// PRESS_WAIT   | s high, counting stable cycles before accepting press
// PRESSED      | button accepted as pressed
// RELEASE_WAIT | s low, counting stable cycles before accepting release
module ena_debounce #(
    parameter int unsigned DEB_CYCLES  = 1000000,
    parameter bit          TOGGLE_MODE = 1'b1,
    parameter bit          ENA_RESET   = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_in,
    output logic       ena,
    output logic       btn_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic [7:0] press_count
);

    localparam int unsigned      CNT_W    = $clog2(DEB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    logic             sync1_q, sync2_q;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             btn_level_q, btn_level_d;
    logic             press_pulse_q, press_pulse_d;
    logic             release_pulse_q, release_pulse_d;
    logic [7:0]       press_count_q, press_count_d;
    logic             ena_q, ena_d;

    // Two-flop synchroniser; only sync2_q is seen by the FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_in;
            sync2_q <= sync1_q;
        end
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        btn_level_d     = btn_level_q;
        press_pulse_d   = 1'b0;
        release_pulse_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (sync2_q) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!sync2_q) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d       = PRESSED;
                    btn_level_d   = 1'b1;
                    press_pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            PRESSED: begin
                if (!sync2_q) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (sync2_q) begin
                    state_d = PRESSED;
                end else if (cnt_q == CNT_LAST) begin
                    state_d         = IDLE;
                    btn_level_d     = 1'b0;
                    release_pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        press_count_d = press_count_q + {7'd0, press_pulse_d};

        // ena is registered on the same edge as the pulse/level it derives from.
        if (TOGGLE_MODE) begin
            ena_d = ena_q ^ press_pulse_d;
        end else begin
            ena_d = btn_level_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            btn_level_q     <= 1'b0;
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
            press_count_q   <= 8'd0;
            ena_q           <= ENA_RESET;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            btn_level_q     <= btn_level_d;
            press_pulse_q   <= press_pulse_d;
            release_pulse_q <= release_pulse_d;
            press_count_q   <= press_count_d;
            ena_q           <= ena_d;
        end
    end

    assign ena           = ena_q;
    assign btn_level     = btn_level_q;
    assign press_pulse   = press_pulse_q;
    assign release_pulse = release_pulse_q;
    assign press_count   = press_count_q;

endmodule
